// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: stage enables, flush/bubble sequencing,
// EX operand forwarding, memory-wait watchdog and performance counters.
module pipeline_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int TIMEOUT      = 1024,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [4:0]       ex_rs1,
    input  logic [4:0]       ex_rs2,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mem_read,
    input  logic [4:0]       mem_rd,
    input  logic             mem_reg_write,
    input  logic [4:0]       wb_rd,
    input  logic             wb_reg_write,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             mem_wb_en,
    output logic             flush_if_id,
    output logic             bubble_ex,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             err_timeout,
    output logic [CNT_W-1:0] cnt_cycles,
    output logic [CNT_W-1:0] cnt_stalls,
    output logic [CNT_W-1:0] cnt_flushes
);

    typedef enum logic [1:0] {RUN, FLUSH, MEM_WAIT} state_e;

    localparam int              WD_W       = $clog2(TIMEOUT + 1);
    localparam logic [2:0]      FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [WD_W-1:0] WD_MAX     = WD_W'(TIMEOUT);

    state_e           state_q, state_d, eff_state;
    logic [2:0]       fcnt_q, fcnt_d;
    logic [WD_W-1:0]  wd_q, wd_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] cyc_q, cyc_d, stl_q, stl_d, fls_q, fls_d;
    logic             load_use, stall, take;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic en);
        return (en && v != '1) ? v + CNT_W'(1) : v;
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
        if (mem_reg_write && mem_rd != 5'd0 && mem_rd == rs)
            return 2'b01;
        else if (wb_reg_write && wb_rd != 5'd0 && wb_rd == rs)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    assign load_use = ex_mem_read && ex_rd != 5'd0 &&
                      ((id_uses_rs1 && id_rs1 == ex_rd) ||
                       (id_uses_rs2 && id_rs2 == ex_rd));

    always_comb begin
        pc_en       = 1'b1;
        if_id_en    = 1'b1;
        id_ex_en    = 1'b1;
        ex_mem_en   = 1'b1;
        mem_wb_en   = 1'b1;
        flush_if_id = 1'b0;
        bubble_ex   = 1'b0;
        fwd_a       = 2'b00;
        fwd_b       = 2'b00;
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        stall       = 1'b0;
        take        = 1'b0;
        // Leaving a freeze resumes whatever the saved flush count implies
        eff_state = state_q;
        if (state_q == MEM_WAIT)
            eff_state = (fcnt_q != 3'd0) ? FLUSH : RUN;
        if (!rst) begin
            fwd_a = fwd_sel(ex_rs1);
            fwd_b = fwd_sel(ex_rs2);
            if (mem_busy) begin
                pc_en     = 1'b0;
                if_id_en  = 1'b0;
                id_ex_en  = 1'b0;
                ex_mem_en = 1'b0;
                mem_wb_en = 1'b0;
                state_d   = MEM_WAIT;
                stall     = 1'b1;
            end else if (branch_taken) begin
                flush_if_id = 1'b1;
                bubble_ex   = 1'b1;
                fcnt_d      = FLUSH_LOAD;
                state_d     = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
                take        = 1'b1;
            end else if (eff_state == FLUSH) begin
                flush_if_id = 1'b1;
                fcnt_d      = fcnt_q - 3'd1;
                state_d     = (fcnt_d == 3'd0) ? RUN : FLUSH;
            end else begin
                state_d = RUN;
                if (load_use) begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    bubble_ex = 1'b1;
                    stall     = 1'b1;
                end
            end
        end
    end

    always_comb begin
        wd_d = '0;
        if (mem_busy)
            wd_d = (wd_q == WD_MAX) ? wd_q : wd_q + WD_W'(1);
        err_d = err_q | (wd_d == WD_MAX);
        cyc_d = sat_inc(cyc_q, 1'b1);
        stl_d = sat_inc(stl_q, stall);
        fls_d = sat_inc(fls_q, take);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            fcnt_q  <= '0;
            wd_q    <= '0;
            err_q   <= 1'b0;
            cyc_q   <= '0;
            stl_q   <= '0;
            fls_q   <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
            wd_q    <= wd_d;
            err_q   <= err_d;
            cyc_q   <= cyc_d;
            stl_q   <= stl_d;
            fls_q   <= fls_d;
        end
    end

    assign err_timeout = err_q;
    assign cnt_cycles  = cyc_q;
    assign cnt_stalls  = stl_q;
    assign cnt_flushes = fls_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl; expected values go through a
// scoreboard queue and are checked with immediate assertions.
module tb_pipeline_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read;
    logic        mem_reg_write, wb_reg_write, branch_taken, mem_busy;
    logic        pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en;
    logic        flush_if_id, bubble_ex, err_timeout;
    logic [1:0]  fwd_a, fwd_b;
    logic [31:0] cnt_cycles, cnt_stalls, cnt_flushes;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_cycles = 0;
    logic [31:0] exp_stalls = 0;
    logic [31:0] exp_flushes = 0;

    pipeline_hazard_ctrl dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read),
        .mem_rd(mem_rd), .mem_reg_write(mem_reg_write),
        .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .branch_taken(branch_taken), .mem_busy(mem_busy),
        .pc_en(pc_en), .if_id_en(if_id_en), .id_ex_en(id_ex_en),
        .ex_mem_en(ex_mem_en), .mem_wb_en(mem_wb_en),
        .flush_if_id(flush_if_id), .bubble_ex(bubble_ex),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .err_timeout(err_timeout),
        .cnt_cycles(cnt_cycles), .cnt_stalls(cnt_stalls),
        .cnt_flushes(cnt_flushes)
    );

    always #5 clk = ~clk;

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.val = v;
        sb.push_back(e);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $error("FAIL %s scoreboard empty, observed %0h", tag, obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                errors++;
                $error("FAIL %s/%s observed %0h expected %0h",
                       tag, e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) exp_cycles = 0;
        else if (exp_cycles != '1) exp_cycles++;
        #1;
    endtask

    task automatic ctl(input string tag, input logic [4:0] en,
                       input logic fl, input logic bb);
        push({tag, ".en"}, {27'd0, en});
        push({tag, ".flush"}, {31'd0, fl});
        push({tag, ".bubble"}, {31'd0, bb});
        #1;
        chk(tag, {27'd0, pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en});
        chk(tag, {31'd0, flush_if_id});
        chk(tag, {31'd0, bubble_ex});
    endtask

    task automatic fwd(input string tag, input logic [1:0] a,
                       input logic [1:0] b);
        push({tag, ".fwd_a"}, {30'd0, a});
        push({tag, ".fwd_b"}, {30'd0, b});
        #1;
        chk(tag, {30'd0, fwd_a});
        chk(tag, {30'd0, fwd_b});
    endtask

    task automatic cnts(input string tag);
        push({tag, ".cycles"}, exp_cycles);
        push({tag, ".stalls"}, exp_stalls);
        push({tag, ".flushes"}, exp_flushes);
        chk(tag, cnt_cycles);
        chk(tag, cnt_stalls);
        chk(tag, cnt_flushes);
    endtask

    task automatic err(input string tag, input logic v);
        push(tag, {31'd0, v});
        chk(tag, {31'd0, err_timeout});
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_mem_read = 0;
        mem_rd = 0; mem_reg_write = 0; wb_rd = 0; wb_reg_write = 0;
        branch_taken = 0; mem_busy = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        // Reset: enables high, nothing flushed, no forwarding
        ex_rs1 = 5'd3; mem_rd = 5'd3; mem_reg_write = 1;
        branch_taken = 1;
        ctl("rst_ctl", 5'b11111, 0, 0);
        fwd("rst_fwd", 2'b00, 2'b00);
        tick();
        tick();
        idle();
        cnts("rst_cnt");
        err("rst_err", 0);
        rst = 1'b0;

        // Load-use on rs1: one stall, then forward from MEM
        ex_mem_read = 1; ex_rd = 5'd5; id_rs1 = 5'd5; id_uses_rs1 = 1;
        ctl("lu_rs1", 5'b00111, 0, 1);
        tick();
        exp_stalls++;
        ex_mem_read = 0; ex_rd = 0; ex_rs1 = 5'd5;
        mem_rd = 5'd5; mem_reg_write = 1;
        ctl("lu_after", 5'b11111, 0, 0);
        fwd("lu_fwd", 2'b01, 2'b00);
        cnts("lu_cnt");
        tick();

        // Load-use on rs2 only
        idle();
        ex_mem_read = 1; ex_rd = 5'd9; id_rs2 = 5'd9; id_uses_rs2 = 1;
        id_rs1 = 5'd9;
        ctl("lu_rs2", 5'b00111, 0, 1);
        tick();
        exp_stalls++;
        id_uses_rs2 = 0;
        ctl("lu_unused", 5'b11111, 0, 0);
        tick();

        // x0 never stalls or forwards
        idle();
        ex_mem_read = 1; id_uses_rs1 = 1; id_uses_rs2 = 1;
        mem_reg_write = 1; wb_reg_write = 1;
        ctl("x0_nostall", 5'b11111, 0, 0);
        fwd("x0_fwd", 2'b00, 2'b00);
        tick();

        // MEM over WB priority, then WB alone
        idle();
        mem_rd = 5'd7; wb_rd = 5'd7; mem_reg_write = 1; wb_reg_write = 1;
        ex_rs2 = 5'd7; ex_rs1 = 5'd7;
        fwd("fwd_mem", 2'b01, 2'b01);
        mem_reg_write = 0; ex_rs1 = 5'd8;
        fwd("fwd_wb", 2'b00, 2'b10);
        tick();

        // Taken branch: flush two cycles, bubble one
        idle();
        branch_taken = 1;
        ex_mem_read = 1; ex_rd = 5'd4; id_rs1 = 5'd4; id_uses_rs1 = 1;
        ctl("br0", 5'b11111, 1, 1);
        tick();
        exp_flushes++;
        idle();
        ctl("br1", 5'b11111, 1, 0);
        tick();
        ctl("br2", 5'b11111, 0, 0);
        cnts("br_cnt");

        // Freeze mid-flush for five cycles
        branch_taken = 1;
        ctl("brf0", 5'b11111, 1, 1);
        tick();
        exp_flushes++;
        branch_taken = 0; mem_busy = 1;
        for (int i = 0; i < 5; i++) begin
            ctl("frz", 5'b00000, 0, 0);
            tick();
            exp_stalls++;
        end
        mem_busy = 0;
        ctl("frz_resume", 5'b11111, 1, 0);
        tick();
        ctl("frz_done", 5'b11111, 0, 0);
        cnts("frz_cnt");

        // Back-to-back branches restart the flush count
        branch_taken = 1;
        ctl("rb0", 5'b11111, 1, 1);
        tick();
        ctl("rb1", 5'b11111, 1, 1);
        tick();
        exp_flushes += 2;
        branch_taken = 0;
        ctl("rb2", 5'b11111, 1, 0);
        tick();
        ctl("rb3", 5'b11111, 0, 0);

        // mem_busy outranks load-use and branch
        mem_busy = 1;
        ex_mem_read = 1; ex_rd = 5'd6; id_rs1 = 5'd6; id_uses_rs1 = 1;
        ctl("busy_lu", 5'b00000, 0, 0);
        tick();
        exp_stalls++;
        idle();
        mem_busy = 1; branch_taken = 1;
        ctl("busy_br", 5'b00000, 0, 0);
        tick();
        exp_stalls++;
        idle();
        ctl("busy_exit", 5'b11111, 0, 0);
        tick();
        cnts("prio_cnt");

        // Watchdog fires after TIMEOUT consecutive busy cycles
        mem_busy = 1;
        for (int i = 0; i < 1023; i++) tick();
        err("wd_1023", 0);
        tick();
        exp_stalls += 1024;
        err("wd_1024", 1);
        mem_busy = 0;
        tick();
        tick();
        err("wd_sticky", 1);
        cnts("wd_cnt");

        rst = 1;
        tick();
        rst = 0;
        err("wd_rst", 0);
        exp_stalls = 0; exp_flushes = 0;
        cnts("rst2_cnt");

        // Reset during FLUSH drops the pending flush
        branch_taken = 1;
        ctl("rf_br", 5'b11111, 1, 1);
        tick();
        branch_taken = 0;
        rst = 1;
        ctl("rf_inrst", 5'b11111, 0, 0);
        tick();
        rst = 0;
        ctl("rf_after", 5'b11111, 0, 0);
        tick();
        exp_stalls = 0; exp_flushes = 0;
        cnts("rf_cnt");

        checks++;
        assert (sb.size() == 0) else begin
            errors++;
            $error("FAIL sb_drain observed %0d expected 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central hazard and sequencing controller for the 5-stage pipeline (fetch, decode, execute, memory, writeback). It produces per-stage register enables, bubble and flush controls, and EX-operand forwarding selects. It sequences load-use stalls, multi-cycle taken-branch flushes and data-memory wait freezes, with a watchdog and saturating performance counters. It replaces the ad-hoc branch squash in the pipeline top; the top gates its stage registers with these outputs.

Parameters:
FLUSH_CYCLES, 2, cycles IF/ID is flushed after a taken branch (1..7; covers fetch memory latency)
TIMEOUT, 1024, max consecutive mem_busy cycles before err_timeout
CNT_W, 32, width of performance counters

Ports:
clk  in  1  clock
rst  in  1  reset
id_rs1  in  5  decode-stage source reg 1
id_rs2  in  5  decode-stage source reg 2
id_uses_rs1  in  1  decode instr reads rs1
id_uses_rs2  in  1  decode instr reads rs2
ex_rs1  in  5  execute-stage source reg 1
ex_rs2  in  5  execute-stage source reg 2
ex_rd  in  5  execute-stage destination
ex_mem_read  in  1  execute instr is a load
mem_rd  in  5  memory-stage destination
mem_reg_write  in  1  memory-stage writes a register
wb_rd  in  5  writeback-stage destination
wb_reg_write  in  1  writeback-stage writes a register
branch_taken  in  1  is_branch & branch_taken from execute
mem_busy  in  1  data memory not ready this cycle
pc_en  out  1  PC register update enable
if_id_en  out  1  IF/ID register enable
id_ex_en  out  1  ID/EX register enable
ex_mem_en  out  1  EX/MEM register enable
mem_wb_en  out  1  MEM/WB register enable
flush_if_id  out  1  load NOP into IF/ID
bubble_ex  out  1  load zero control into ID/EX
fwd_a  out  2  EX operand A select: 00 regfile, 01 MEM alu_res, 10 WB data
fwd_b  out  2  EX operand B select, same encoding
err_timeout  out  1  sticky watchdog error
cnt_cycles  out  CNT_W  cycles since reset
cnt_stalls  out  CNT_W  stall or freeze cycles
cnt_flushes  out  CNT_W  taken-branch events

Behaviour:
- Reset (sync, active-high, clk domain):
  - state=RUN, flush counter=0, watchdog=0, err_timeout=0, all counters=0.
  - During reset, all enables=1, flush_if_id=0, bubble_ex=0, fwd=00.
- State register values: RUN, FLUSH, MEM_WAIT. Enables, flush and bubble are combinational from state plus inputs. Priority is mem_busy > branch_taken > load-use.
- Freeze (any state):
  - Trigger: mem_busy=1.
  - All five enables=0, flush_if_id=0, bubble_ex=0.
  - Next state=MEM_WAIT; the flush counter holds its value.
- MEM_WAIT with mem_busy=0:
  - Return to the saved return state: FLUSH if flush counter>0, else RUN.
  - A branch held frozen in EX is re-evaluated on that cycle.
- Taken branch (mem_busy=0, branch_taken=1):
  - Outputs that cycle: flush_if_id=1, bubble_ex=1, all enables=1, cnt_flushes+1.
  - Flush counter loads FLUSH_CYCLES-1. Next state=FLUSH if FLUSH_CYCLES>1, else RUN.
  - A load-use hazard in the same cycle is ignored, since the instruction is squashed.
- FLUSH (mem_busy=0):
  - flush_if_id=1 and counter decrements; go to RUN when the counter reaches 0.
  - A new branch_taken restarts the count (reload FLUSH_CYCLES-1) and increments cnt_flushes again.
- Load-use hazard in RUN:
  - Condition: ex_mem_read & ex_rd!=0 & ((id_uses_rs1 & id_rs1==ex_rd) | (id_uses_rs2 & id_rs2==ex_rd)).
  - Response: pc_en=0, if_id_en=0, bubble_ex=1, others=1. Exactly one stall cycle, because the bubble clears the condition.
- Forwarding (combinational, every state):
  - fwd_a=01 if mem_reg_write & mem_rd!=0 & mem_rd==ex_rs1.
  - Else fwd_a=10 if wb_reg_write & wb_rd!=0 & wb_rd==ex_rs1.
  - Else fwd_a=00. fwd_b is identical using ex_rs2.
  - MEM has priority over WB. x0 never forwards.
- Watchdog:
  - Counts consecutive mem_busy cycles and clears when mem_busy=0.
  - When the count reaches TIMEOUT, err_timeout=1 (sticky until rst).
- Counters:
  - cnt_cycles increments every non-reset cycle.
  - cnt_stalls increments on freeze or load-use stall cycles.
  - All counters saturate at all-ones, with no wrap.
- Reset mid-operation (during a flush, freeze or stall): next cycle is in RUN with reset values; no pending flush survives.

Test Plan:
- Load x5 in EX, ID add reads rs1=x5 -> exactly 1 cycle of pc_en=0, if_id_en=0, bubble_ex=1; cnt_stalls=1; fwd_a=01 on the next cycle.
- Load with ex_rd=0, ID reads x0 -> no stall; mem_rd=wb_rd=0 with reg_write=1 -> fwd=00.
- mem_rd=wb_rd=7 both writing, ex_rs2=7 -> fwd_b=01; clear mem_reg_write -> fwd_b=10.
- branch_taken for 1 cycle, FLUSH_CYCLES=2 -> flush_if_id high 2 cycles, bubble_ex high 1 cycle, cnt_flushes=1.
- branch_taken then mem_busy=1 for 5 cycles mid-flush -> enables 0 for 5 cycles, then flush_if_id 1 more cycle; cnt_stalls=5.
- mem_busy held 1024 cycles (TIMEOUT=1024) -> err_timeout rises and stays high after mem_busy drops; rst clears it; rst during FLUSH -> RUN, flush_if_id=0 next cycle.
